// File: rtl/perf_counter_bank_if.sv
// Register-port bundle for perf_counter_bank: word-addressed write/read strobes
// with a registered 32-bit read return.
interface perf_counter_bank_if #(
  parameter int unsigned ADDR_W = 7
) ();
  logic              we;
  logic              re;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              rvalid;

  modport master (output we, re, addr, wdata, input rdata, rvalid);
  modport slave  (input we, re, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/perf_counter_bank.sv
// Memory-mapped bank of NUM_CH event counters with stall gating, sticky overflow,
// masked irq and an all-channel snapshot. Optional thresholds: PERF_CNT_THRESH_EN.
module perf_counter_bank #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 48,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [NUM_CH-1:0] event_in,
  input  logic              stall,
  perf_counter_bank_if.slave bus,
  output logic              irq
);

  localparam int unsigned CH_BASE  = 8;
  localparam int unsigned THR_BASE = 72;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              global_en, global_en_d;
  logic [NUM_CH-1:0] en, en_d, gate, gate_d, imask, imask_d;
  logic [NUM_CH-1:0] ovf, ovf_d, ovf_set, ovf_w1c, cnt_c;
  logic [CNT_W-1:0]  live   [NUM_CH];
  logic [CNT_W-1:0]  live_d [NUM_CH];
  logic [CNT_W-1:0]  snap   [NUM_CH];
  logic [CNT_W-1:0]  snap_d [NUM_CH];
  logic [31:0]       rdata_d;
  logic              irq_d;
  logic              snap_p, clr_p;
`ifdef PERF_CNT_THRESH_EN
  logic [31:0]       thresh   [NUM_CH];
  logic [31:0]       thresh_d [NUM_CH];
  logic [NUM_CH-1:0] thr, thr_d, thr_set, thr_w1c;
`endif

  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       a, ch_off;
  logic              chan_hit;

  assign addr_q   = bus.addr;
  assign a        = 32'(addr_q);
  assign ch_off   = a - CH_BASE;
  assign chan_hit = (a >= CH_BASE) && (a < CH_BASE + 4 * NUM_CH);
  assign cnt_c    = {NUM_CH{global_en}} & en & event_in & ~(gate & {NUM_CH{stall}});

  // Next-state: register writes, live priority (clear_all > preload > increment), read mux
  always_comb begin
    global_en_d = global_en;
    en_d        = en;
    gate_d      = gate;
    imask_d     = imask;
    ovf_set     = '0;
    ovf_w1c     = '0;
    live_d      = live;
    snap_d      = snap;
    snap_p      = 1'b0;
    clr_p       = 1'b0;
    rdata_d     = bus.rdata;
`ifdef PERF_CNT_THRESH_EN
    thresh_d    = thresh;
    thr_set     = '0;
    thr_w1c     = '0;
`endif
    if (bus.we) begin
      if (a == 32'd0) begin
        global_en_d = bus.wdata[0];
        snap_p      = bus.wdata[1];
        clr_p       = bus.wdata[2];
      end
      if (a == 32'd1) ovf_w1c = bus.wdata[NUM_CH-1:0];
      if (a == 32'd2) imask_d = bus.wdata[NUM_CH-1:0];
`ifdef PERF_CNT_THRESH_EN
      if (a == 32'd3) thr_w1c = bus.wdata[NUM_CH-1:0];
`endif
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.we && chan_hit && (ch_off[31:2] == 30'(i)) && (ch_off[1:0] == 2'd0)) begin
        en_d[i]   = bus.wdata[0];
        gate_d[i] = bus.wdata[1];
      end
      if (snap_p) snap_d[i] = live[i];
      if (clr_p) begin
        live_d[i] = '0;
      end else if (bus.we && chan_hit && (ch_off[31:2] == 30'(i)) && (ch_off[1:0] == 2'd1)) begin
        live_d[i] = CNT_W'(bus.wdata);
      end else if (cnt_c[i]) begin
        live_d[i]  = live[i] + CNT_W'(1);
        ovf_set[i] = (live[i] == CNT_MAX);
      end
`ifdef PERF_CNT_THRESH_EN
      if (bus.we && (a == 32'(THR_BASE + i))) thresh_d[i] = bus.wdata;
      thr_set[i] = (32'(live_d[i]) == thresh[i]) && (32'(live[i]) != thresh[i]);
`endif
    end
    // Set wins over a same-cycle W1C
    ovf_d = (ovf & ~ovf_w1c) | ovf_set;
`ifdef PERF_CNT_THRESH_EN
    thr_d = (thr & ~thr_w1c) | thr_set;
    irq_d = (|(ovf_d & imask)) | (|(thr_d & imask));
`else
    irq_d = |(ovf_d & imask);
`endif

    // Read mux samples pre-write state, so a same-cycle write is not visible
    if (bus.re) begin
      rdata_d = '0;
      if (a == 32'd0) rdata_d = 32'(global_en);
      if (a == 32'd1) rdata_d = 32'(ovf);
      if (a == 32'd2) rdata_d = 32'(imask);
`ifdef PERF_CNT_THRESH_EN
      if (a == 32'd3) rdata_d = 32'(thr);
`endif
      for (int i = 0; i < NUM_CH; i++) begin
        if (chan_hit && (ch_off[31:2] == 30'(i))) begin
          case (ch_off[1:0])
            2'd0:    rdata_d = {30'd0, gate[i], en[i]};
            2'd1:    rdata_d = 32'(live[i]);
            2'd2:    rdata_d = 32'(snap[i]);
            default: rdata_d = 32'(64'(snap[i]) >> 32);
          endcase
        end
`ifdef PERF_CNT_THRESH_EN
        if (a == 32'(THR_BASE + i)) rdata_d = thresh[i];
`endif
      end
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      global_en  <= 1'b0;
      en         <= '0;
      gate       <= '0;
      imask      <= '0;
      ovf        <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        live[i] <= '0;
        snap[i] <= '0;
      end
      bus.rdata  <= '0;
      bus.rvalid <= 1'b0;
      irq        <= 1'b0;
`ifdef PERF_CNT_THRESH_EN
      thr        <= '0;
      for (int i = 0; i < NUM_CH; i++) thresh[i] <= '1;
`endif
    end else begin
      global_en  <= global_en_d;
      en         <= en_d;
      gate       <= gate_d;
      imask      <= imask_d;
      ovf        <= ovf_d;
      live       <= live_d;
      snap       <= snap_d;
      bus.rdata  <= rdata_d;
      bus.rvalid <= bus.re;
      irq        <= irq_d;
`ifdef PERF_CNT_THRESH_EN
      thr        <= thr_d;
      thresh     <= thresh_d;
`endif
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: a 48-bit and an 8-bit instance share one stimulus
// stream and are compared every cycle against a per-width behavioural model.
module tb_perf_counter_bank;

  logic        CLK = 1'b0;
  logic        reset;
  logic [3:0]  ev;
  logic        stall, we, re;
  logic [6:0]  addr;
  logic [31:0] wdata;
  logic        irq48, irq8;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 CLK = ~CLK;

  perf_counter_bank_if #(.ADDR_W(7)) b48 ();
  perf_counter_bank_if #(.ADDR_W(7)) b8 ();

  assign b48.we = we;  assign b48.re = re;  assign b48.addr = addr;  assign b48.wdata = wdata;
  assign b8.we  = we;  assign b8.re  = re;  assign b8.addr  = addr;  assign b8.wdata  = wdata;

  perf_counter_bank #(.NUM_CH(4), .CNT_W(48), .ADDR_W(7)) dut48 (
    .CLK(CLK), .reset(reset), .event_in(ev), .stall(stall), .bus(b48), .irq(irq48));
  perf_counter_bank #(.NUM_CH(4), .CNT_W(8), .ADDR_W(7)) dut8 (
    .CLK(CLK), .reset(reset), .event_in(ev), .stall(stall), .bus(b8), .irq(irq8));

  // Model state, index k: 0 = 48-bit instance, 1 = 8-bit instance
  logic [63:0] m_live [2][4];
  logic [63:0] m_snap [2][4];
  logic        m_en   [2][4];
  logic        m_gate [2][4];
  logic [3:0]  m_ovf  [2];
  logic [3:0]  m_mask [2];
  logic        m_gen  [2];
  logic        m_irq  [2];
  logic [31:0] m_rdata[2];
  logic        m_rvalid;

  function automatic logic [63:0] wmask(input int k);
    return (k == 0) ? 64'h0000_FFFF_FFFF_FFFF : 64'h0000_0000_0000_00FF;
  endfunction

  function automatic logic [31:0] model_read(input int k, input int ad);
    int ch, r;
    if (ad == 0) return {31'd0, m_gen[k]};
    if (ad == 1) return {28'd0, m_ovf[k]};
    if (ad == 2) return {28'd0, m_mask[k]};
    if (ad >= 8 && ad < 24) begin
      ch = (ad - 8) / 4;
      r  = (ad - 8) % 4;
      if (r == 0) return {30'd0, m_gate[k][ch], m_en[k][ch]};
      if (r == 1) return m_live[k][ch][31:0];
      if (r == 2) return m_snap[k][ch][31:0];
      return m_snap[k][ch][63:32];
    end
    return 32'd0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 4; c++) begin
        m_live[k][c] = 64'd0; m_snap[k][c] = 64'd0; m_en[k][c] = 1'b0; m_gate[k][c] = 1'b0;
      end
      m_ovf[k] = 4'd0; m_mask[k] = 4'd0; m_gen[k] = 1'b0; m_irq[k] = 1'b0; m_rdata[k] = 32'd0;
    end
    m_rvalid = 1'b0;
  endtask

  // One clock of specified behaviour, using the inputs held across the edge
  task automatic model_step();
    int ad;
    logic [31:0] rd;
    logic snp, clr, cnt;
    logic [3:0] set, oldmask;
    ad = int'(addr);
    for (int k = 0; k < 2; k++) begin
      rd      = model_read(k, ad);
      snp     = we && ad == 0 && wdata[1];
      clr     = we && ad == 0 && wdata[2];
      set     = 4'd0;
      oldmask = m_mask[k];
      for (int c = 0; c < 4; c++) begin
        cnt = m_gen[k] && m_en[k][c] && ev[c] && !(m_gate[k][c] && stall);
        if (snp) m_snap[k][c] = m_live[k][c];
        if (clr) m_live[k][c] = 64'd0;
        else if (we && ad == 9 + 4 * c) m_live[k][c] = {32'd0, wdata} & wmask(k);
        else if (cnt) begin
          if (m_live[k][c] == wmask(k)) set[c] = 1'b1;
          m_live[k][c] = (m_live[k][c] + 64'd1) & wmask(k);
        end
      end
      if (we) begin
        if (ad == 0) m_gen[k] = wdata[0];
        if (ad == 1) m_ovf[k] = m_ovf[k] & ~wdata[3:0];
        if (ad == 2) m_mask[k] = wdata[3:0];
        for (int c = 0; c < 4; c++)
          if (ad == 8 + 4 * c) begin m_en[k][c] = wdata[0]; m_gate[k][c] = wdata[1]; end
      end
      m_ovf[k] = m_ovf[k] | set;
      m_irq[k] = |(m_ovf[k] & oldmask);
      if (re) m_rdata[k] = rd;
    end
    m_rvalid = re;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("rvalid48", {31'd0, b48.rvalid}, {31'd0, m_rvalid});
    check("rdata48",  b48.rdata, m_rdata[0]);
    check("irq48",    {31'd0, irq48}, {31'd0, m_irq[0]});
    check("rvalid8",  {31'd0, b8.rvalid}, {31'd0, m_rvalid});
    check("rdata8",   b8.rdata, m_rdata[1]);
    check("irq8",     {31'd0, irq8}, {31'd0, m_irq[1]});
  endtask

  task automatic step(input logic w, input logic r, input logic [6:0] ad,
                      input logic [31:0] wd, input logic [3:0] e, input logic s);
    we = w; re = r; addr = ad; wdata = wd; ev = e; stall = s;
    @(posedge CLK);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic wr(input logic [6:0] ad, input logic [31:0] wd);
    step(1'b1, 1'b0, ad, wd, 4'd0, 1'b0);
  endtask

  task automatic rd(input logic [6:0] ad);
    step(1'b0, 1'b1, ad, 32'd0, 4'd0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge CLK);
    reset = 1'b1;
  endtask

  initial begin
    logic [6:0]  ra;
    logic [31:0] rw;
    we = 0; re = 0; addr = '0; wdata = '0; ev = '0; stall = 0;
    do_reset();

    // Reset readback
    rd(7'h00); check("rst_gctrl", b48.rdata, 32'd0);
    rd(7'h01); check("rst_ovf",   b48.rdata, 32'd0);
    rd(7'h09); check("rst_live0", b48.rdata, 32'd0);
    step(0, 0, 7'h00, 32'd0, 4'd0, 0);

    // Basic count: ch0 enabled, ch1 disabled
    wr(7'h00, 32'd1);
    wr(7'h08, 32'd1);
    for (int j = 0; j < 10; j++) step(0, 0, 7'h00, 32'd0, 4'b0011, 0);
    rd(7'h09); check("live0_10_w48", b48.rdata, 32'd10); check("live0_10_w8", b8.rdata, 32'd10);
    rd(7'h0D); check("live1_off", b48.rdata, 32'd0);

    // Stall gating, then gating disabled
    wr(7'h0C, 32'd3); wr(7'h0D, 32'd0);
    for (int j = 0; j < 8; j++) step(0, 0, 7'h00, 32'd0, 4'b0010, j < 3);
    rd(7'h0D); check("live1_gated", b48.rdata, 32'd5);
    wr(7'h0C, 32'd1); wr(7'h0D, 32'd0);
    for (int j = 0; j < 8; j++) step(0, 0, 7'h00, 32'd0, 4'b0010, j < 3);
    rd(7'h0D); check("live1_ungated", b48.rdata, 32'd8);

    // Overflow and irq on the 8-bit instance
    wr(7'h11, 32'hFE); wr(7'h10, 32'd1); wr(7'h02, 32'h4);
    step(0, 0, 7'h00, 32'd0, 4'b0100, 0);
    step(0, 0, 7'h00, 32'd0, 4'b0100, 0);
    check("irq8_ovf", {31'd0, irq8}, 32'd1);
    rd(7'h01); check("ovf8", b8.rdata, 32'h4); check("ovf48", b48.rdata, 32'h0);
    rd(7'h11); check("live2_wrap8", b8.rdata, 32'h0);
    wr(7'h01, 32'h4); check("irq8_cleared", {31'd0, irq8}, 32'd0);
    wr(7'h11, 32'hFF);
    step(1, 0, 7'h01, 32'h4, 4'b0100, 0);
    rd(7'h01); check("ovf8_set_wins", b8.rdata, 32'h4);
    wr(7'h01, 32'hF);

    // Snapshot coherence across the 32-bit boundary
    wr(7'h09, 32'hFFFF_FFFF);
    step(1, 0, 7'h00, 32'h3, 4'b0001, 0);
    step(0, 1, 7'h0B, 32'd0, 4'b0001, 0); check("snaphi_0", b48.rdata, 32'd0);
    step(0, 1, 7'h0A, 32'd0, 4'b0001, 0); check("snaplo_ff", b48.rdata, 32'hFFFF_FFFF);
    wr(7'h09, 32'hFFFF_FFFF);
    step(1, 0, 7'h00, 32'h3, 4'b0001, 0);
    step(1, 0, 7'h00, 32'h3, 4'b0000, 0);
    rd(7'h0B); check("snaphi_1", b48.rdata, 32'd1);
    rd(7'h0A); check("snaplo_0", b48.rdata, 32'd0);

    // Same-cycle priority on LIVE_3
    wr(7'h14, 32'd1); wr(7'h15, 32'h33);
    step(1, 0, 7'h00, 32'h5, 4'b1000, 0);
    rd(7'h15); check("prio_clear", b48.rdata, 32'd0);
    step(1, 0, 7'h15, 32'h55, 4'b1000, 0);
    rd(7'h15); check("prio_write", b48.rdata, 32'h55);
    step(1, 1, 7'h15, 32'h77, 4'd0, 0); check("rw_same_addr", b48.rdata, 32'h55);
    rd(7'h15); check("rw_after", b48.rdata, 32'h77);
    rd(7'h03); check("unmapped_thr", b48.rdata, 32'd0);
    rd(7'h48); check("unmapped_thresh", b48.rdata, 32'd0);

    // Reset mid-operation
    step(0, 1, 7'h09, 32'd0, 4'b1111, 0);
    do_reset();
    rd(7'h15); check("post_rst_live3", b48.rdata, 32'd0);

    // Randomised traffic against the model
    wr(7'h00, 32'd1);
    for (int j = 0; j < 500; j++) begin
      case ($urandom_range(0, 5))
        0:       ra = 7'h00;
        1:       ra = 7'(1 + $urandom_range(0, 2));
        2:       ra = 7'($urandom_range(0, 127));
        default: ra = 7'(8 + $urandom_range(0, 15));
      endcase
      case ($urandom_range(0, 4))
        0:       rw = 32'hFF;
        1:       rw = 32'hFE;
        2:       rw = 32'hFFFF_FFFE;
        default: rw = $urandom;
      endcase
      if (ra == 7'h00 && $urandom_range(0, 7) != 0) rw = rw | 32'd1;
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1), ra, rw,
           4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
